// File: rtl/rs_array.sv
// rs_array: multi-entry reservation station.
// Holds dispatched instructions until both operands are resolved, snoops the
// CDB ports to capture late operands, and issues the oldest ready entry
// through a valid/ready handshake. An age matrix tracks relative order:
// r_age[i][j] == 1 means entry i is older than entry j.
module rs_array #(
  parameter int NUM_ENTRIES = 8,
  parameter int NUM_CDB     = 2,
  parameter int TAG_W       = 5,
  parameter int XLEN        = 32,
  parameter int PAYLOAD_W   = 64
) (
  input  logic                                 clock,
  input  logic                                 reset_n,
  input  logic                                 squash,
  input  logic                                 disp_valid,
  output logic                                 disp_ready,
  input  logic [PAYLOAD_W-1:0]                 disp_payload,
  input  logic [TAG_W-1:0]                     disp_dest_tag,
  input  logic [TAG_W-1:0]                     disp_rs1_tag,
  input  logic [XLEN-1:0]                      disp_rs1_value,
  input  logic [TAG_W-1:0]                     disp_rs2_tag,
  input  logic [XLEN-1:0]                      disp_rs2_value,
  input  logic [NUM_CDB-1:0]                   cdb_valid,
  input  logic [NUM_CDB*TAG_W-1:0]             cdb_tag,
  input  logic [NUM_CDB*XLEN-1:0]              cdb_value,
  output logic                                 iss_valid,
  input  logic                                 iss_ready,
  output logic [PAYLOAD_W-1:0]                 iss_payload,
  output logic [TAG_W-1:0]                     iss_dest_tag,
  output logic [XLEN-1:0]                      iss_rs1_value,
  output logic [XLEN-1:0]                      iss_rs2_value,
  output logic [$clog2(NUM_ENTRIES+1)-1:0]     free_count
);

  localparam int IDX_W = $clog2(NUM_ENTRIES);
  localparam int CNT_W = $clog2(NUM_ENTRIES + 1);

  // Snoop all CDB ports for a tag. Returns {hit, value}; tag 0 never hits and
  // the lowest-index matching port wins (loop runs high to low so the last
  // assignment comes from the lowest port).
  function automatic logic [XLEN:0] f_snoop(
    input logic [TAG_W-1:0]         tag,
    input logic [NUM_CDB-1:0]       vld,
    input logic [NUM_CDB*TAG_W-1:0] tags,
    input logic [NUM_CDB*XLEN-1:0]  vals
  );
    logic [XLEN:0] res;
    res = '0;
    for (int p = NUM_CDB - 1; p >= 0; p--) begin
      if ((tag != '0) && vld[p] && (tags[p*TAG_W +: TAG_W] == tag)) begin
        res = {1'b1, vals[p*XLEN +: XLEN]};
      end else begin
        res = res;
      end
    end
    return res;
  endfunction

  // Entry state
  logic [NUM_ENTRIES-1:0] r_busy;
  logic [PAYLOAD_W-1:0]   r_payload   [NUM_ENTRIES];
  logic [TAG_W-1:0]       r_dest_tag  [NUM_ENTRIES];
  logic [TAG_W-1:0]       r_rs1_tag   [NUM_ENTRIES];
  logic [XLEN-1:0]        r_rs1_value [NUM_ENTRIES];
  logic [TAG_W-1:0]       r_rs2_tag   [NUM_ENTRIES];
  logic [XLEN-1:0]        r_rs2_value [NUM_ENTRIES];
  logic [NUM_ENTRIES-1:0] r_age       [NUM_ENTRIES];
  logic [CNT_W-1:0]       r_free_count;
  // Selection lock: holds the chosen entry while the consumer stalls so that
  // an older entry waking up cannot change the presented instruction.
  logic                   r_lock;
  logic [IDX_W-1:0]       r_lock_idx;

  logic [NUM_ENTRIES-1:0] w_ready;
  logic [NUM_ENTRIES-1:0] w_oldest_hot;
  logic [IDX_W-1:0]       w_oldest_idx;
  logic [IDX_W-1:0]       w_sel_idx;
  logic [IDX_W-1:0]       w_free_idx;
  logic                   w_disp_fire;
  logic                   w_iss_fire;
  logic [XLEN:0]          w_disp_rs1;
  logic [XLEN:0]          w_disp_rs2;
  logic [XLEN:0]          w_rs1_wake [NUM_ENTRIES];
  logic [XLEN:0]          w_rs2_wake [NUM_ENTRIES];

  assign disp_ready  = (r_free_count != '0);
  assign free_count  = r_free_count;
  assign w_disp_fire = disp_valid && disp_ready;
  assign iss_valid   = |w_ready;
  assign w_iss_fire  = iss_valid && iss_ready;
  assign w_sel_idx   = (r_lock && w_ready[r_lock_idx]) ? r_lock_idx : w_oldest_idx;

  assign iss_payload   = iss_valid ? r_payload[w_sel_idx]   : '0;
  assign iss_dest_tag  = iss_valid ? r_dest_tag[w_sel_idx]  : '0;
  assign iss_rs1_value = iss_valid ? r_rs1_value[w_sel_idx] : '0;
  assign iss_rs2_value = iss_valid ? r_rs2_value[w_sel_idx] : '0;

  // Dispatch operand snoop for same-cycle wakeup
  assign w_disp_rs1 = f_snoop(disp_rs1_tag, cdb_valid, cdb_tag, cdb_value);
  assign w_disp_rs2 = f_snoop(disp_rs2_tag, cdb_valid, cdb_tag, cdb_value);

  // Per-entry readiness and CDB wakeup match
  always_comb begin
    for (int i = 0; i < NUM_ENTRIES; i++) begin
      w_ready[i]    = r_busy[i] && (r_rs1_tag[i] == '0) && (r_rs2_tag[i] == '0);
      w_rs1_wake[i] = f_snoop(r_rs1_tag[i], cdb_valid, cdb_tag, cdb_value);
      w_rs2_wake[i] = f_snoop(r_rs2_tag[i], cdb_valid, cdb_tag, cdb_value);
    end
  end

  // Lowest-index free entry for dispatch
  always_comb begin
    w_free_idx = '0;
    for (int i = NUM_ENTRIES - 1; i >= 0; i--) begin
      w_free_idx = !r_busy[i] ? IDX_W'(i) : w_free_idx;
    end
  end

  // Oldest ready entry: ready and older than every other ready entry
  always_comb begin
    w_oldest_hot = '0;
    w_oldest_idx = '0;
    for (int i = 0; i < NUM_ENTRIES; i++) begin
      w_oldest_hot[i] = w_ready[i];
      for (int j = 0; j < NUM_ENTRIES; j++) begin
        w_oldest_hot[i] = w_oldest_hot[i] & ((j == i) || !w_ready[j] || r_age[i][j]);
      end
    end
    for (int i = NUM_ENTRIES - 1; i >= 0; i--) begin
      w_oldest_idx = w_oldest_hot[i] ? IDX_W'(i) : w_oldest_idx;
    end
  end

  // Entry storage: dispatch write, CDB capture, issue release, squash clear
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_busy <= '0;
      for (int i = 0; i < NUM_ENTRIES; i++) begin
        r_payload[i]   <= '0;
        r_dest_tag[i]  <= '0;
        r_rs1_tag[i]   <= '0;
        r_rs1_value[i] <= '0;
        r_rs2_tag[i]   <= '0;
        r_rs2_value[i] <= '0;
      end
    end else if (squash) begin
      r_busy <= '0;
      for (int i = 0; i < NUM_ENTRIES; i++) begin
        r_payload[i]   <= '0;
        r_dest_tag[i]  <= '0;
        r_rs1_tag[i]   <= '0;
        r_rs1_value[i] <= '0;
        r_rs2_tag[i]   <= '0;
        r_rs2_value[i] <= '0;
      end
    end else begin
      for (int i = 0; i < NUM_ENTRIES; i++) begin
        if (w_disp_fire && (w_free_idx == IDX_W'(i))) begin
          r_busy[i]      <= 1'b1;
          r_payload[i]   <= disp_payload;
          r_dest_tag[i]  <= disp_dest_tag;
          r_rs1_tag[i]   <= w_disp_rs1[XLEN] ? '0 : disp_rs1_tag;
          r_rs1_value[i] <= w_disp_rs1[XLEN] ? w_disp_rs1[XLEN-1:0] : disp_rs1_value;
          r_rs2_tag[i]   <= w_disp_rs2[XLEN] ? '0 : disp_rs2_tag;
          r_rs2_value[i] <= w_disp_rs2[XLEN] ? w_disp_rs2[XLEN-1:0] : disp_rs2_value;
        end else begin
          if (w_iss_fire && (w_sel_idx == IDX_W'(i))) begin
            r_busy[i] <= 1'b0;
          end
          if (r_busy[i] && w_rs1_wake[i][XLEN]) begin
            r_rs1_tag[i]   <= '0;
            r_rs1_value[i] <= w_rs1_wake[i][XLEN-1:0];
          end
          if (r_busy[i] && w_rs2_wake[i][XLEN]) begin
            r_rs2_tag[i]   <= '0;
            r_rs2_value[i] <= w_rs2_wake[i][XLEN-1:0];
          end
        end
      end
    end
  end

  // Age matrix: a new entry is younger than every currently busy entry
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < NUM_ENTRIES; i++) begin
        r_age[i] <= '0;
      end
    end else if (squash) begin
      for (int i = 0; i < NUM_ENTRIES; i++) begin
        r_age[i] <= '0;
      end
    end else if (w_disp_fire) begin
      for (int i = 0; i < NUM_ENTRIES; i++) begin
        if (w_free_idx == IDX_W'(i)) begin
          r_age[i] <= '0;
        end else begin
          r_age[i][w_free_idx] <= r_busy[i];
        end
      end
    end
  end

  // Free-entry counter: dispatch consumes a slot, issue returns one
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_free_count <= CNT_W'(NUM_ENTRIES);
    end else if (squash) begin
      r_free_count <= CNT_W'(NUM_ENTRIES);
    end else begin
      r_free_count <= r_free_count - CNT_W'(w_disp_fire) + CNT_W'(w_iss_fire);
    end
  end

  // Selection lock: remember the presented entry while the consumer stalls
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_lock     <= 1'b0;
      r_lock_idx <= '0;
    end else if (squash) begin
      r_lock     <= 1'b0;
      r_lock_idx <= '0;
    end else begin
      r_lock     <= iss_valid && !iss_ready;
      r_lock_idx <= w_sel_idx;
    end
  end

endmodule

// File: doc/rs_array.md
Name: rs_array

Overview:
- Multi-entry reservation station. Generalises the single-entry dispatch/wakeup slot into a parametrised array of NUM_ENTRIES slots.
- Dispatch: accepts one decoded instruction per cycle, with operand tags/values already resolved against the map table and ROB.
- Wakeup: snoops NUM_CDB broadcast ports each cycle.
- Issue: selects the oldest ready entry for one issue per cycle through a valid/ready handshake.
- Sits between dispatch (decoder, map table, ROB) and the execute stage. Supports full-pipeline squash.

Parameters:
NUM_ENTRIES, 8, number of RS slots (power of two not required, >=2)
NUM_CDB, 2, number of CDB broadcast ports snooped per cycle
TAG_W, 5, ROB tag width; tag 0 reserved as "value ready"
XLEN, 32, operand value width
PAYLOAD_W, 64, opaque decoded-instruction bits carried unchanged to issue

Ports:
clock  in  1  system clock, rising edge
reset_n  in  1  asynchronous, active-low reset
squash  in  1  flush all entries
disp_valid  in  1  dispatch request
disp_ready  out  1  a free entry exists
disp_payload  in  PAYLOAD_W  decoded instruction bits
disp_dest_tag  in  TAG_W  ROB entry of this instruction
disp_rs1_tag  in  TAG_W  producer tag, 0 = value valid
disp_rs1_value  in  XLEN  operand 1 value (used when tag 0)
disp_rs2_tag  in  TAG_W  producer tag, 0 = value valid
disp_rs2_value  in  XLEN  operand 2 value (used when tag 0)
cdb_valid  in  NUM_CDB  per-port broadcast valid
cdb_tag  in  NUM_CDB*TAG_W  packed broadcast tags, port 0 in LSBs
cdb_value  in  NUM_CDB*XLEN  packed broadcast values
iss_valid  out  1  selected entry ready to issue
iss_ready  in  1  execute stage accepts
iss_payload  out  PAYLOAD_W  selected entry payload
iss_dest_tag  out  TAG_W  selected entry ROB tag
iss_rs1_value  out  XLEN  resolved operand 1
iss_rs2_value  out  XLEN  resolved operand 2
free_count  out  $clog2(NUM_ENTRIES+1)  number of non-busy entries

Behaviour:
- Reset (reset_n low, asynchronous):
  - All entries not busy; tags, values, payloads and age matrix cleared.
  - disp_ready=1, iss_valid=0, free_count=NUM_ENTRIES, all iss_* data outputs 0.
  - Deassertion is sampled synchronously. Reset mid-operation discards all entries with no issue.
- Per-entry state: busy, payload, dest_tag, rs1_tag, rs1_value, rs2_tag, rs2_value.
  - Entry is ready when busy && rs1_tag==0 && rs2_tag==0.
- Dispatch:
  - A dispatch fires when disp_valid && disp_ready. It writes the lowest-index non-busy entry at the clock edge.
  - disp_ready = (free_count != 0), from registered state only. A same-cycle issue does not open a slot for a same-cycle dispatch.
- Same-cycle wakeup on dispatch:
  - If disp_rsX_tag != 0 and it matches a valid CDB port this cycle, store tag 0 and that port's value.
  - Otherwise store the incoming tag and value.
- Wakeup of busy entries:
  - For each busy entry and operand with tag != 0, a match against any valid CDB port loads cdb_value and sets tag to 0 at the edge.
  - cdb_tag==0 never matches. If several ports carry the same tag, the lowest-index port wins.
- Issue latency: an entry becomes eligible the cycle after its last operand is captured. There is no combinational CDB-to-issue bypass.
- Select:
  - iss_valid = any ready entry. The oldest ready entry is chosen using an NUM_ENTRIES x NUM_ENTRIES age matrix.
  - On dispatch, the new entry is marked younger than all currently busy entries.
  - iss_* outputs are combinational from registered state and stay 0 when iss_valid=0.
  - Selection is stable while iss_valid && !iss_ready, unless squash occurs.
- Issue handshake: iss_valid && iss_ready frees the selected entry at the edge. At most one issue per cycle.
- free_count: registered; next = current - dispatch_fire + issue_fire. A simultaneous dispatch and issue leaves it unchanged.
- Squash: all entries are cleared at the next edge and free_count becomes NUM_ENTRIES.
  - Squash overrides any same-cycle dispatch, issue or wakeup. The issue handshake in a squash cycle is still reported on outputs, but the consumer must drop it.
- Full: disp_ready=0 when free_count==0, and disp_valid is ignored.
- Empty: iss_valid=0.

Test Plan:
- Reset then dispatch: tags 0, values 0x11/0x22, dest 3, iss_ready=1 → next cycle iss_valid=1, rs1=0x11, rs2=0x22, dest_tag=3; following cycle free_count=8.
- CDB wakeup: dispatch rs1_tag=5. CDB port 1 broadcasts tag 5, value 0xABCD two cycles later → iss_valid rises the cycle after the broadcast with rs1_value=0xABCD. No broadcast means iss_valid stays 0.
- Same-cycle wakeup: dispatch rs2_tag=7 while CDB port 0 sends tag 7, value 0x55 → entry issues next cycle with rs2_value=0x55.
- Age order: dispatch A (tag 4 pending), then B and C (ready); broadcast tag 4 → issue order B, C, A with iss_ready held 1. Hold iss_ready=0 for 3 cycles → B's outputs stay stable throughout.
- Full/back-pressure: 8 dispatches with iss_ready=0 → free_count=0, disp_ready=0, and a 9th disp_valid is dropped. One issue → disp_ready=1 next cycle.
- Squash and async reset: squash with a concurrent dispatch → next cycle free_count=8, iss_valid=0. Assert reset_n low mid-cycle → outputs reach reset values immediately, without waiting for a clock edge.
